// File: rtl/disp_fifo_ctrl.sv
// Show-ahead FIFO controller around an external two-port SRAM with a 1-cycle registered read.
// A 2-entry output buffer hides the read latency so a steady stream passes at one word per cycle.
module disp_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] sram_addr_w,
    output logic [DATA_WIDTH-1:0] sram_din_w,
    output logic                  sram_ce_w,
    output logic                  sram_en_w,
    output logic [ADDR_WIDTH-1:0] sram_addr_r,
    output logic                  sram_ce_r,
    output logic                  sram_en_r,
    input  logic [DATA_WIDTH-1:0] sram_dout_r,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = ADDR_WIDTH + 2;
    localparam logic [CW-1:0] SRAM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         sram_cnt, sram_cnt_nxt;
    logic                  rd_pend, rd_pend_nxt;
    logic [1:0]            buf_cnt, buf_cnt_nxt;
    logic [1:0]            occ_after, keep_cnt;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic [TW-1:0]         count_q;
    logic                  push, pop, rd_issue;

    // in_ready is gated by rst_n so nothing is accepted while the block is held in reset
    always_comb begin
        in_ready     = rst_n & ~flush & (sram_cnt != SRAM_FULL);
        push         = in_valid & in_ready;
        out_valid    = ~flush & (buf_cnt != 2'd0);
        pop          = out_valid & out_ready;
        keep_cnt     = buf_cnt - {1'b0, pop};
        occ_after    = keep_cnt + {1'b0, rd_pend};
        rd_issue     = (sram_cnt != '0) & (occ_after < 2'd2) & ~flush;

        sram_cnt_nxt = sram_cnt + CW'(push) - CW'(rd_issue);
        rd_pend_nxt  = rd_issue;
        buf_cnt_nxt  = occ_after;
        if (flush) begin
            sram_cnt_nxt = '0;
            rd_pend_nxt  = 1'b0;
            buf_cnt_nxt  = 2'd0;
        end
    end

    assign sram_ce_w   = ~push;
    assign sram_en_w   = ~push;
    assign sram_addr_w = wr_ptr;
    assign sram_din_w  = in_data;
    assign sram_ce_r   = ~rd_issue;
    assign sram_en_r   = ~rd_issue;
    assign sram_addr_r = rd_ptr;
    assign out_data    = obuf[0];
    assign count       = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            rd_pend  <= 1'b0;
            buf_cnt  <= 2'd0;
            count_q  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)     wr_ptr <= wr_ptr + 1'b1;
                if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            end
            sram_cnt <= sram_cnt_nxt;
            rd_pend  <= rd_pend_nxt;
            buf_cnt  <= buf_cnt_nxt;
            count_q  <= TW'(sram_cnt_nxt) + TW'(rd_pend_nxt) + TW'(buf_cnt_nxt);
        end
    end

    // Capture lands at the slot left after any pop; the later write wins when both hit entry 0
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (pop)     obuf[0] <= obuf[1];
            if (rd_pend) obuf[keep_cnt[0]] <= sram_dout_r;
        end
    end

endmodule

// File: tb/tb_disp_fifo_ctrl.sv
// Self-checking bench for disp_fifo_ctrl with a 16-deep SRAM model and a queue-based reference model.
module tb_disp_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data, sram_din_w, sram_dout_r;
    logic [AW-1:0] sram_addr_w, sram_addr_r;
    logic          sram_ce_w, sram_en_w, sram_ce_r, sram_en_r;
    logic [AW+1:0] count;

    int checks = 0;
    int failures = 0;

    disp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sram_addr_w(sram_addr_w), .sram_din_w(sram_din_w),
        .sram_ce_w(sram_ce_w), .sram_en_w(sram_en_w),
        .sram_addr_r(sram_addr_r), .sram_ce_r(sram_ce_r), .sram_en_r(sram_en_r),
        .sram_dout_r(sram_dout_r), .count(count)
    );

    always #5 clk = ~clk;

    // External SRAM: registered read, output floats when no read was strobed last cycle
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data = '0;
    logic          rd_valid = 1'b0;
    always @(posedge clk) begin
        if (!sram_ce_w && !sram_en_w) mem[sram_addr_w] <= sram_din_w;
        rd_valid <= !sram_ce_r && !sram_en_r;
        if (!sram_ce_r && !sram_en_r) rd_data <= mem[sram_addr_r];
    end
    assign sram_dout_r = rd_valid ? rd_data : 'z;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words waiting in SRAM, word on the read bus, words buffered for output
    logic [DW-1:0] m_sram[$];
    logic [DW-1:0] m_flight[$];
    logic [DW-1:0] m_buf[$];
    int            m_wr = 0;
    int            m_rd = 0;
    logic          c_push = 1'b0, c_pop = 1'b0, c_issue = 1'b0;
    logic [DW-1:0] c_data = '0;

    always @(negedge clk) begin : compare
        int  ns, nf, nb;
        logic e_ir, e_ov;
        ns      = m_sram.size();
        nf      = m_flight.size();
        nb      = m_buf.size();
        e_ir    = rst_n && !flush && (ns < DEPTH);
        e_ov    = rst_n && !flush && (nb > 0);
        c_pop   = e_ov && out_ready;
        c_push  = e_ir && in_valid;
        c_data  = in_data;
        c_issue = rst_n && !flush && (ns > 0) && ((nb + nf - int'(c_pop)) < 2);
        checkOutput("in_ready", in_ready, e_ir);
        checkOutput("out_valid", out_valid, e_ov);
        if (e_ov) checkOutput("out_data", out_data, m_buf[0]);
        checkOutput("count", count, ns + nf + nb);
        checkOutput("sram_ce_w", sram_ce_w, !c_push);
        checkOutput("sram_en_w", sram_en_w, !c_push);
        if (c_push) begin
            checkOutput("sram_addr_w", sram_addr_w, m_wr);
            checkOutput("sram_din_w", sram_din_w, in_data);
        end
        checkOutput("sram_ce_r", sram_ce_r, !c_issue);
        checkOutput("sram_en_r", sram_en_r, !c_issue);
        checkOutput("sram_addr_r", sram_addr_r, m_rd);
        if (!sram_ce_w && !sram_ce_r)
            checkOutput("addr collision", sram_addr_w == sram_addr_r, 1'b0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            m_sram.delete(); m_flight.delete(); m_buf.delete();
            m_wr = 0; m_rd = 0;
        end else begin
            if (c_pop) void'(m_buf.pop_front());
            if (m_flight.size() != 0) m_buf.push_back(m_flight.pop_front());
            if (c_issue) begin
                m_flight.push_back(m_sram.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (c_push) begin
                m_sram.push_back(c_data);
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic singleWord(input logic [DW-1:0] d, input string tag);
        applyStimulus(1'b1, d, 1'b1, 1'b0);
        @(negedge clk); checkOutput({tag, " push accepted"}, in_ready, 1'b1);
        nextCycle(); in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, " ce_r cycle1"}, sram_ce_r, 1'b0);
        checkOutput({tag, " en_r cycle1"}, sram_en_r, 1'b0);
        nextCycle();
        @(negedge clk); checkOutput({tag, " out_valid cycle2"}, out_valid, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, " out_valid cycle3"}, out_valid, 1'b1);
        checkOutput({tag, " out_data cycle3"}, out_data, d);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, " count after"}, count, 0);
        checkOutput({tag, " out_valid after"}, out_valid, 1'b0);
        nextCycle();
    endtask

    task automatic drain();
        int i;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (i = 0; i < 200 && count != 0; i++) nextCycle();
        checkOutput("drain empty", count, 0);
    endtask

    task automatic fillTest();
        int acc = 0, got = 0, bad = 0, ir_cyc = -1;
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            nextCycle();
            in_data = DW'(acc);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("fill accepted", acc, 18);
        checkOutput("fill count", count, 18);
        checkOutput("fill in_ready low", in_ready, 1'b0);
        nextCycle();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 18; c++) begin
            @(negedge clk);
            if (in_ready && ir_cyc < 0) ir_cyc = c;
            if (out_valid) begin
                if (out_data !== DW'(got)) bad++;
                got++;
            end
            nextCycle();
        end
        checkOutput("fill drained", got, 18);
        checkOutput("fill order errors", bad, 0);
        checkOutput("fill in_ready return cycle", ir_cyc, 1);
    endtask

    task automatic streamTest();
        int sent = 0, got = 0, first = -1, last = -1, bad = 0, cyc = 0;
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
        while (got < 1000 && cyc < 3000) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (out_data !== DW'(got)) bad++;
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            nextCycle();
            cyc++;
            in_valid = (sent < 1000);
            in_data  = DW'(sent);
        end
        in_valid = 1'b0;
        checkOutput("stream words", got, 1000);
        checkOutput("stream first pop cycle", first, 3);
        checkOutput("stream span", last - first, 999);
        checkOutput("stream order errors", bad, 0);
    endtask

    task automatic randomTest();
        int sent = 0, got = 0, cyc = 0;
        while (got < 10000 && cyc < 60000) begin
            applyStimulus((sent < 10000) && ($urandom_range(3) != 0), DW'($urandom),
                          $urandom_range(2) != 0, 1'b0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got++;
            nextCycle();
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("random words drained", got, 10000);
    endtask

    task automatic flushTest();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
            nextCycle();
        end
        in_valid = 1'b0;
        repeat (3) nextCycle();
        applyStimulus(1'b1, 8'hB0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush count before", count, 7);
        checkOutput("flush out_valid during", out_valid, 1'b0);
        checkOutput("flush in_ready during", in_ready, 1'b0);
        checkOutput("flush no read strobe", sram_ce_r, 1'b1);
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush count after", count, 0);
        checkOutput("flush out_valid after", out_valid, 1'b0);
        nextCycle();
        singleWord(8'h11, "post-flush");
    endtask

    task automatic resetTest();
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            in_data = DW'(8'h41 + i);
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset in_ready", in_ready, 1'b0);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset ce_w", sram_ce_w, 1'b1);
        checkOutput("reset en_w", sram_en_w, 1'b1);
        checkOutput("reset ce_r", sram_ce_r, 1'b1);
        checkOutput("reset en_r", sram_en_r, 1'b1);
        checkOutput("reset count", count, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        singleWord(8'h3C, "post-reset");
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        singleWord(8'h5A, "single");
        fillTest();
        drain();
        streamTest();
        drain();
        randomTest();
        drain();
        flushTest();
        resetTest();
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_fifo_ctrl.md
# disp_fifo_ctrl

Single-clock show-ahead FIFO controller for the disparity output path. It wraps an external two-port SRAM that has active-low chip/write/read enables and a 1-cycle registered read. It turns a valid/ready input stream into a valid/ready output stream. It generates all SRAM strobes and hides the SRAM read latency with a 2-entry output buffer, so a steady stream passes at one word per cycle.

## Interface
- DATA_WIDTH, 8: word width.
- ADDR_WIDTH, 10: SRAM address width. Depth is DEPTH = 2^ADDR_WIDTH.
- clk  in  1  single clock for the block and the SRAM (both SRAM clock pins are tied to it).
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- in_valid  in  1  / in_ready  out  1 / in_data  in  DATA_WIDTH: write-side handshake.
- out_valid  out  1 / out_ready  in  1 / out_data  out  DATA_WIDTH: read-side handshake.
- sram_addr_w  out  ADDR_WIDTH / sram_din_w  out  DATA_WIDTH / sram_ce_w  out  1 / sram_en_w  out  1: SRAM write port, strobes active-low.
- sram_addr_r  out  ADDR_WIDTH / sram_ce_r  out  1 / sram_en_r  out  1: SRAM read port, strobes active-low.
- sram_dout_r  in  DATA_WIDTH: SRAM read data. Valid in the cycle after a read strobe; Z otherwise.
- count  out  ADDR_WIDTH+2: total words held. Range 0..DEPTH+2.

## Operation
- State:
  - wr_ptr, rd_ptr: ADDR_WIDTH each; wrap modulo DEPTH naturally.
  - sram_cnt: 0..DEPTH; words in SRAM not yet read-issued.
  - rd_pend: 1 bit; a read was issued last cycle.
  - obuf: 2-entry register FIFO; buf_cnt 0..2.
- push = in_valid & in_ready.
  - in_ready = (sram_cnt < DEPTH) & ~flush.
- Write path, combinational:
  - On push: sram_ce_w = 0, sram_en_w = 0, sram_addr_w = wr_ptr, sram_din_w = in_data.
  - Otherwise both strobes are 1.
  - wr_ptr increments on push.
- pop = out_valid & out_ready.
  - out_valid = (buf_cnt != 0) & ~flush.
  - out_data = obuf head.
- Read issue:
  - Condition: rd_issue = (sram_cnt != 0) & ((buf_cnt + rd_pend - pop) < 2) & ~flush.
  - On rd_issue: sram_ce_r = 0, sram_en_r = 0, sram_addr_r = rd_ptr; rd_ptr increments.
  - Otherwise both strobes are 1 and sram_addr_r holds rd_ptr.
- sram_cnt next = sram_cnt + push - rd_issue.
  - A word written in cycle t is readable from cycle t+1.
- Capture: when rd_pend = 1, sram_dout_r is written into obuf at the tail, in the same edge as any pop.
  - sram_dout_r is never sampled when rd_pend = 0.
- count = sram_cnt + rd_pend + buf_cnt. Maximum is DEPTH+2.
- No read/write address collision by construction: when a write and a read issue occur together, 0 < sram_cnt < DEPTH, so wr_ptr != rd_ptr.
- Flush cycle:
  - No SRAM strobes. in_ready = 0, out_valid = 0.
  - Next state: pointers, sram_cnt, rd_pend and buf_cnt all 0. obuf data is don't-care.
  - A read in flight from the previous cycle is discarded.
- Reset (rst_n low, asynchronous) sets the same state as flush.
  - While rst_n is low: in_ready = 0, out_valid = 0, all SRAM strobes = 1, count = 0.
  - in_ready rises in the first cycle after release.
  - Reset mid-stream discards all data. The SRAM array contents are irrelevant.

## Timing
- Empty-FIFO latency, push to out_valid = 3 cycles:
  - Push in cycle 0.
  - Read issue in cycle 1.
  - sram_dout_r valid in cycle 2; captured at the end of cycle 2.
  - out_valid in cycle 3.
- Throughput is 1 word/cycle sustained with out_ready held high.
  - Steady state: buf_cnt = 1, rd_pend = 1, one issue per cycle.
- Full:
  - in_ready drops the cycle after sram_cnt reaches DEPTH.
  - in_ready returns the cycle after the next read issue.
  - Simultaneous push and issue at sram_cnt = DEPTH-1 keeps it at DEPTH-1.
- Empty: out_valid is low whenever buf_cnt = 0, even if rd_pend = 1.
- Simultaneous capture and pop with buf_cnt = 2 cannot occur.
  - Issue rule: buf_cnt + rd_pend never exceeds 2 after the update.
- All outputs except the SRAM write strobes/data, in_ready, out_valid and sram read strobes are registered.
  - Those exceptions are combinational from handshake inputs, flush and registered state.

## Test plan
- Single word: push 0x5A at cycle 0, out_ready = 1.
  - Required: read strobes low in cycle 1.
  - Required: out_valid with out_data = 0x5A in cycle 3, then count = 0.
- Fill: out_ready = 0, push continuously with DEPTH = 16 (ADDR_WIDTH = 4).
  - Required: exactly 18 words accepted; in_ready low thereafter; count = 18.
  - Then pop all 18 in order; in_ready reasserts after the first pop-driven issue.
- Streaming: 1000 incrementing words, in_valid and out_ready always high.
  - Required: one word out per cycle after the 3-cycle fill; data in order; pointers wrap cleanly.
- Random backpressure: random in_valid/out_ready, 10k words.
  - Required: scoreboard exact order.
  - Required: SRAM addr_w never equals addr_r while both strobe sets are active.
  - Required: sram_dout_r is sampled only when rd_pend = 1.
- Flush mid-stream with a read in flight (count = 7).
  - Required: next cycle count = 0 and out_valid = 0.
  - Required: a subsequent push of 0x11 emerges 3 cycles later as the only word.
- Async reset asserted mid-stream between clock edges.
  - Required: outputs go to reset values immediately, with no SRAM strobe.
  - Required: after release, operation resumes as in the single-word test.
